// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin/lockable two-requester sequencer that drives the accumulator ALU one cycle per command
module alu_arbiter #(
  parameter int W = 2,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [7:0]      req_op,
  input  logic [2*W-1:0]  req_a,
  input  logic [1:0]      req_lock,
  output logic [1:0]      rsp_valid,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_err,
  output logic [3:0]      alu_opcode,
  output logic [W-1:0]    alu_a,
  input  logic [W-1:0]    alu_out,
  output logic            busy,
  output logic [CW-1:0]   issue_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic last, locked, owner, id, sel, hs, legal;
  logic [3:0] op;
  logic [W-1:0] a;
  always_comb begin
    sel = locked ? owner : (&req_valid ? ~last : req_valid[1]);
    req_ready = (state == IDLE && req_valid[sel]) ? {sel, ~sel} : 2'b00;
    hs = |req_ready;
    op = sel ? req_op[7:4] : req_op[3:0];
    a = sel ? req_a[2*W-1:W] : req_a[W-1:0];
    legal = op == 4'b0000 || op == 4'b0001 || op == 4'b0101 || op == 4'b1001;
    state_nx = state == IDLE ? (hs ? (legal ? ISSUE : RESP) : IDLE) : state == ISSUE ? RESP : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last <= 1'b1;
      locked <= 1'b0;
      owner <= 1'b0;
      id <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      alu_opcode <= 4'b0000;
      alu_a <= '0;
      issue_cnt <= '0;
    end else begin
      state <= state_nx;
      alu_opcode <= (hs && legal) ? op : 4'b0000;
      alu_a <= (hs && legal) ? a : '0;
      rsp_valid <= 2'b00;
      rsp_err <= 1'b0;
      if (hs) begin
        last <= sel;
        id <= sel;
        // only the owner can be granted while locked, so its lock bit alone decides
        locked <= req_lock[sel];
        owner <= sel;
        if (!legal) begin
          rsp_valid <= {sel, ~sel};
          rsp_err <= 1'b1;
          rsp_data <= '0;
        end
      end
      if (state == ISSUE) begin
        rsp_data <= alu_out;
        issue_cnt <= issue_cnt + CW'(1);
        rsp_valid <= {id, ~id};
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, lock, issue timing, errors, reset and counter wrap
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req_valid = 2'b00, req_ready, req_lock = 2'b00, rsp_valid;
  logic [7:0] req_op = 8'h00;
  logic [3:0] req_a = 4'h0;
  logic [1:0] rsp_data, alu_a, alu_out;
  logic rsp_err, busy;
  logic [3:0] alu_opcode;
  logic [7:0] issue_cnt;
  logic [1:0] acc = 2'b00;
  int compared = 0, mismatched = 0;
  int issues = 0, adds = 0, b2b_alu = 0, b2b_rsp = 0, rsp_cnt = 0;
  logic [3:0] prev_op = 4'h0;
  logic [1:0] prev_rv = 2'b00;

  alu_arbiter #(.W(2), .CW(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_lock(req_lock), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_out(alu_out),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // accumulator datapath stand-in
  always_comb begin
    alu_out = acc;
    if (alu_opcode == 4'b0001) alu_out = 2'b00;
    else if (alu_opcode == 4'b0101) alu_out = acc + alu_a;
    else if (alu_opcode == 4'b1001) alu_out = acc & alu_a;
  end
  always @(posedge clk) acc <= alu_out;

  always @(negedge clk) begin
    if (alu_opcode != 4'h0) issues++;
    if (alu_opcode == 4'b0101) adds++;
    if (alu_opcode != 4'h0 && prev_op != 4'h0) b2b_alu++;
    if (rsp_valid != 2'b00) rsp_cnt++;
    if (rsp_valid != 2'b00 && prev_rv != 2'b00) b2b_rsp++;
    prev_op = alu_opcode;
    prev_rv = rsp_valid;
  end

  task automatic wait_hs(output int k);
    k = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        k = req_ready[1] ? 1 : 0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy && rsp_valid == 2'b00) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [3:0] op, input logic [1:0] a, input logic lk,
                      output logic [1:0] d, output logic e, output int lat, output logic [1:0] rv);
    int g;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req_valid[k] = 1'b1;
    req_op[4*k +: 4] = op;
    req_a[2*k +: 2] = a;
    req_lock[k] = lk;
    wait_hs(g);
    req_valid = 2'b00;
    req_lock = 2'b00;
    lat = 0;
    rv = 2'b00;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      lat = n;
      if (rsp_valid[k]) break;
    end
    d = rsp_data;
    e = rsp_err;
    rv = rsp_valid;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    compared++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, alu_opcode, alu_a, busy, issue_cnt} !== 22'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {req_ready, rsp_valid, rsp_data, rsp_err, alu_opcode, alu_a, busy, issue_cnt});
    end
    #2 rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [1:0] d, rv;
    logic e;
    int lat, i0, a0;
    i0 = issues;
    a0 = adds;
    send(0, 4'b0001, 2'b00, 1'b0, d, e, lat, rv);
    compared++;
    if (d !== 2'b00 || lat !== 2 || e !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_reset_op: got d=%0h lat=%0d err=%0b expected d=0 lat=2 err=0", d, lat, e);
    end
    send(0, 4'b0101, 2'b01, 1'b0, d, e, lat, rv);
    compared++;
    if (d !== 2'b01 || lat !== 2) begin
      mismatched++;
      $display("FAIL basic_add1: got d=%0h lat=%0d expected d=1 lat=2", d, lat);
    end
    send(0, 4'b0101, 2'b01, 1'b0, d, e, lat, rv);
    compared++;
    if (d !== 2'b10) begin
      mismatched++;
      $display("FAIL basic_add2: got %0h expected 2", d);
    end
    compared++;
    if (issue_cnt !== 8'd3) begin
      mismatched++;
      $display("FAIL basic_issue_cnt: got %0d expected 3", issue_cnt);
    end
    compared++;
    if (adds - a0 !== 2 || issues - i0 !== 3 || b2b_alu !== 0) begin
      mismatched++;
      $display("FAIL basic_alu_cycles: got adds=%0d issues=%0d b2b=%0d expected 2 3 0", adds - a0, issues - i0, b2b_alu);
    end
  endtask

  task automatic test_and;
    logic [1:0] d, rv;
    logic e;
    int lat;
    send(0, 4'b0101, 2'b01, 1'b0, d, e, lat, rv);
    compared++;
    if (d !== 2'b11) begin
      mismatched++;
      $display("FAIL and_setup: got %0h expected 3", d);
    end
    send(1, 4'b1001, 2'b10, 1'b0, d, e, lat, rv);
    compared++;
    if (d !== 2'b10 || rv !== 2'b10 || e !== 1'b0) begin
      mismatched++;
      $display("FAIL and_req1: got d=%0h rv=%0b err=%0b expected d=2 rv=10 err=0", d, rv, e);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    int exp_k[4] = '{0, 1, 0, 1};
    @(posedge clk);
    #1;
    req_op = 8'h55;
    req_a = 4'b0101;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_hs(k);
      if (i == 3) req_valid = 2'b00;
      compared++;
      if (k !== exp_k[i]) begin
        mismatched++;
        $display("FAIL rr_grant%0d: got %0d expected %0d", i, k, exp_k[i]);
      end
    end
    wait_idle();
    compared++;
    if (b2b_rsp !== 0 || b2b_alu !== 0) begin
      mismatched++;
      $display("FAIL rr_spacing: got b2b_rsp=%0d b2b_alu=%0d expected 0 0", b2b_rsp, b2b_alu);
    end
  endtask

  task automatic test_lock;
    logic [1:0] d, rv;
    logic e;
    int lat, k;
    send(1, 4'b0101, 2'b01, 1'b1, d, e, lat, rv);
    @(posedge clk);
    #1;
    req_op = 8'h55;
    req_a = 4'b0101;
    req_lock = 2'b00;
    req_valid = 2'b11;
    wait_hs(k);
    compared++;
    if (k !== 1) begin
      mismatched++;
      $display("FAIL lock_hold: got %0d expected 1", k);
    end
    wait_hs(k);
    req_valid = 2'b00;
    compared++;
    if (k !== 0) begin
      mismatched++;
      $display("FAIL lock_release: got %0d expected 0", k);
    end
    wait_idle();
  endtask

  task automatic test_illegal;
    logic [1:0] d, rv;
    logic e;
    int lat, i0;
    logic [7:0] c0;
    i0 = issues;
    c0 = issue_cnt;
    send(0, 4'b0111, 2'b11, 1'b0, d, e, lat, rv);
    compared++;
    if (e !== 1'b1 || lat !== 1 || d !== 2'b00 || rv !== 2'b01) begin
      mismatched++;
      $display("FAIL illegal_rsp: got err=%0b lat=%0d d=%0h rv=%0b expected 1 1 0 01", e, lat, d, rv);
    end
    wait_idle();
    compared++;
    if (issue_cnt !== c0 || issues !== i0) begin
      mismatched++;
      $display("FAIL illegal_noissue: got cnt=%0d issues=%0d expected %0d %0d", issue_cnt, issues, c0, i0);
    end
  endtask

  task automatic test_reset_mid;
    int k, r0;
    req_op = 8'h05;
    req_a = 4'b0001;
    req_valid = 2'b01;
    wait_hs(k);
    req_valid = 2'b00;
    compared++;
    if (alu_opcode !== 4'b0101) begin
      mismatched++;
      $display("FAIL rstmid_issue: got %0h expected 5", alu_opcode);
    end
    r0 = rsp_cnt;
    rst = 1'b0;
    #1;
    compared++;
    if (alu_opcode !== 4'b0000 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_async: got op=%0h busy=%0b expected 0 0", alu_opcode, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if (rsp_cnt !== r0 || issue_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL rstmid_norsp: got rsp=%0d cnt=%0d expected %0d 0", rsp_cnt - r0, issue_cnt, 0);
    end
    @(posedge clk);
    #1;
    req_op = 8'h00;
    req_valid = 2'b11;
    wait_hs(k);
    req_valid = 2'b00;
    compared++;
    if (k !== 0) begin
      mismatched++;
      $display("FAIL rstmid_tie: got %0d expected 0", k);
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
    end
    compared++;
    if (rsp_data !== 2'b01) begin
      mismatched++;
      $display("FAIL rstmid_noop_data: got %0h expected 1", rsp_data);
    end
    wait_idle();
  endtask

  task automatic test_wrap;
    logic [1:0] d, rv;
    logic e;
    int lat;
    for (int i = 0; i < 254; i++) send(0, 4'b0000, 2'b00, 1'b0, d, e, lat, rv);
    compared++;
    if (issue_cnt !== 8'd255) begin
      mismatched++;
      $display("FAIL wrap_max: got %0d expected 255", issue_cnt);
    end
    send(0, 4'b0000, 2'b00, 1'b0, d, e, lat, rv);
    compared++;
    if (issue_cnt !== 8'd0 || d !== 2'b01) begin
      mismatched++;
      $display("FAIL wrap_zero: got cnt=%0d d=%0h expected 0 1", issue_cnt, d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_and();
    test_back_to_back();
    test_lock();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Arbiter and sequencer sitting in front of the breadboard accumulator ALU. It shares the ALU's opcode and operand-A ports between two requesters using round-robin arbitration with an optional lock. Each accepted command is driven onto the ALU for exactly one clock, and NOOP is driven at all other times, so the accumulator can never be left in a repeating ADD state. The post-operation accumulator value is returned to the requester that issued the command.

## Interface
- `W`, default 2: ALU data width, matching the accumulator width.
- `CW`, default 8: width of the issue counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 2: bit k means requester k presents a command.
- `req_ready` out 2: bit k means requester k's command is accepted this cycle.
- `req_op` in 8: opcodes; requester k's opcode is bits [4k+3:4k].
- `req_a` in 2*W: operands; requester k's operand is bits [W*k+W-1:W*k].
- `req_lock` in 2: requester k asks to keep the grant after this command.
- `rsp_valid` out 2: one-cycle response strobe to requester k.
- `rsp_data` out W: accumulator result, shared by both requesters; qualify it with `rsp_valid`.
- `rsp_err` out 1: response is for an illegal opcode; qualify it with `rsp_valid`.
- `alu_opcode` out 4: drives the ALU opcode/mux select.
- `alu_a` out W: drives ALU operand A.
- `alu_out` in W: the ALU mux output, i.e. the next accumulator value.
- `busy` out 1: high whenever the block is not in IDLE.
- `issue_cnt` out CW: count of legal operations issued to the ALU; wraps modulo 2^CW.

## Operation
- Legal opcodes:
  - 4'b0000 NOOP
  - 4'b0001 RESET
  - 4'b0101 ADD
  - 4'b1001 AND
- Every other opcode is illegal. An illegal command is accepted but never issued.
- The FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - `req_ready` is nonzero only in IDLE, and only for the granted requester.
  - On a handshake (`req_valid[k] & req_ready[k]`), the block registers the opcode, operand and k.
  - Next state is ISSUE if the opcode is legal, otherwise RESP with the error flag set.
- ISSUE:
  - `alu_opcode` = registered opcode and `alu_a` = registered operand, both for this one cycle only.
  - At the end of the cycle: `rsp_data` ← `alu_out`, `issue_cnt` increments, next state is RESP.
- RESP:
  - `alu_opcode` = NOOP and `alu_a` = 0.
  - `rsp_valid[k]` = 1 for this one cycle.
  - `rsp_err` = 1 only for an illegal command; in that case `rsp_data` = 0.
  - Next state is IDLE.
- Outside ISSUE, `alu_opcode` = 4'b0000 and `alu_a` = 0.
- Round-robin arbitration:
  - A pointer `last` records the requester most recently accepted.
  - If both requesters are valid, the grant goes to the one that is not `last`.
  - If only one is valid, it is granted.
- Lock:
  - If `req_lock[k]` = 1 at acceptance, `owner` = k is set and only k may be granted afterwards, even if the other requester is valid.
  - An accepted command from the owner with `req_lock` = 0 clears the lock.
- A NOOP command is legal and is issued; it returns the current accumulator value.
- `req_valid` may drop without a handshake; no state changes in that case.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `alu_a` = 0.
  - `alu_opcode` = 4'b0000, `busy` = 0, `issue_cnt` = 0.
  - `last` = 1, so requester 0 wins the first tie.
  - Lock cleared.
- Legal command: handshake in cycle T, ALU issue in T+1, response in T+2, next acceptance possible in T+3.
- Illegal command: handshake in T, response in T+1, next acceptance possible in T+2.
- ALU issue is exactly one cycle; two consecutive cycles of non-NOOP opcode can never occur.
- `req_ready` is combinational from state, `req_valid`, `last` and lock; all other outputs are registered.
- Reset mid-operation (assertion is asynchronous): `alu_opcode` goes to NOOP immediately and any pending response is discarded. The accumulator state in the datapath is not touched by this block.
- `issue_cnt` at 2^CW−1 followed by an issue gives 0.

## Test plan
- Reset, then req0 issues RESET; then req0 issues ADD a=01, ADD a=01 → responses 00, 01, 10 in turn; `alu_opcode` is 0101 for exactly one cycle per ADD; `issue_cnt` = 3.
- Accumulator at 11, req1 issues AND a=10 → `rsp_valid[1]`, `rsp_data` = 10.
- Both requesters valid continuously with ADD a=01 → acceptances alternate 0,1,0,1; no response is issued in two consecutive cycles; every ALU issue is separated by NOOP.
- req1 ADD with lock=1, then req0 and req1 both valid → req1 is granted again; req1 ADD with lock=0 → the next grant goes to req0.
- req0 opcode 0111 → accepted, `rsp_err` = 1 one cycle after the handshake, `alu_opcode` stays 0000, `issue_cnt` unchanged.
- `rst` pulled low during ISSUE → `alu_opcode` = 0000 immediately; no `rsp_valid` follows; after release, req0 wins the first tie.
